// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants and state encoding for the 16-channel mux scan controller.
package mux_scan_ctrl_pkg;

    localparam int CH_COUNT = 16;
    localparam int SEL_W    = 4;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Scans a downstream 16:1 selector: steps sel through 0..15, waits SETTLE
// cycles after each change, samples mux_out, and publishes all 16 samples
// at once on data when the scan completes.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        mux_out,
    output logic [0:3]  sel,
    output logic        busy,
    output logic        done,
    output logic [0:15] data
);

    // The parameter SETTLE hides the package state literal of the same name,
    // so that one state is always referenced through the package scope.
    localparam state_t ST_SETTLE = mux_scan_ctrl_pkg::SETTLE;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [0:SEL_W-1] SEL_LAST    = SEL_W'(CH_COUNT - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [0:CH_COUNT-1]   shadow;
    logic [0:CH_COUNT-1]   shadow_smp;
    logic                  busy_nxt;
    logic                  done_nxt;

    // State register plus registered busy/done so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers see pre-edge values.
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state decode: abort only matters while a scan is in flight; DONE always returns to IDLE.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !abort) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)                    state_nxt = IDLE;
                else if (cnt == SETTLE_LAST)  state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (abort)                    state_nxt = IDLE;
                else if (sel == SEL_LAST)     state_nxt = DONE;
                else                          state_nxt = ST_SETTLE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the next state, registered alongside the state.
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    // Shadow image with the current channel's sample merged in, so the last
    // channel lands in data on the same edge that enters DONE.
    always_comb begin
        shadow_smp      = shadow;
        shadow_smp[sel] = mux_out;
    end

    // Datapath: settle counter, channel select, sample shadow and published data.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel    <= '0;
            cnt    <= '0;
            shadow <= '0;
            data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        sel <= '0;
                        cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        sel    <= '0;
                        cnt    <= '0;
                        shadow <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        sel    <= '0;
                        cnt    <= '0;
                        shadow <= '0;
                    end else begin
                        shadow <= shadow_smp;
                        cnt    <= '0;
                        if (sel == SEL_LAST) data <= shadow_smp;
                        else                 sel  <= sel + SEL_W'(1);
                    end
                end
                default: begin
                    // DONE holds everything; the copy to data already happened on entry.
                end
            endcase
        end
    end

endmodule
